// File: rtl/pico_mips_mc.sv
// pico_mips_mc: multi-cycle pico MIPS core with synchronous instruction ROM,
// iterative restoring divider, HALT state, run-enable freeze and ALU flags.
module pico_mips_mc #(
   parameter  int DATA_W  = 8,
   parameter  int REG_NUM = 32,
   parameter  int PC_W    = 8,
   parameter  int IN_W    = 9,
   localparam int RA_W    = $clog2(REG_NUM),
   localparam int INSTR_W = 6 + 2*RA_W + DATA_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run_en,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic [IN_W-1:0]    sw,
   output logic [DATA_W-1:0]  led,
   output logic [3:0]         flags,
   output logic               halted
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_DIV, S_HALT} state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   regs_q [REG_NUM];
   logic [DATA_W-1:0]   regs_d [REG_NUM];
   logic [DATA_W-1:0]   led_q, led_d;
   logic [3:0]          flags_q, flags_d;
   logic [DATA_W-1:0]   quo_q, quo_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RA_W-1:0]     drd_q, drd_d;

   logic [5:0]          op;
   logic [RA_W-1:0]     rd, rs;
   logic [DATA_W-1:0]   imm, a, b, add_b;
   logic [DATA_W:0]     sum, dif;
   logic [2*DATA_W-1:0] prod;
   logic [IN_W+DATA_W-1:0] sw_ext;
   logic [DATA_W:0]     rem_sh, trial;
   logic [DATA_W-1:0]   quo_nx, rem_nx;
   logic [3:0]          add_fl, sub_fl;
   logic                unused_bits;

   assign op  = imem_rdata[INSTR_W-1 -: 6];
   assign rd  = imem_rdata[INSTR_W-7 -: RA_W];
   assign rs  = imem_rdata[INSTR_W-7-RA_W -: RA_W];
   assign imm = imem_rdata[DATA_W-1:0];
   assign a   = regs_q[rd];
   assign b   = regs_q[rs];

   always_comb begin
      add_b  = (op[3:0] == 4'd8) ? imm : b;
      sum    = {1'b0, a} + {1'b0, add_b};
      dif    = {1'b0, a} - {1'b0, b};
      prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      sw_ext = {{DATA_W{1'b0}}, sw};
      add_fl = {sum[DATA_W-1],
                (a[DATA_W-1] == add_b[DATA_W-1]) &&
                (sum[DATA_W-1] != a[DATA_W-1]),
                sum[DATA_W],
                sum[DATA_W-1:0] == '0};
      sub_fl = {dif[DATA_W-1],
                (a[DATA_W-1] != b[DATA_W-1]) &&
                (dif[DATA_W-1] != a[DATA_W-1]),
                dif[DATA_W],
                dif[DATA_W-1:0] == '0};
      // restoring step; a zero divisor never borrows, giving all-ones
      rem_sh = {rem_q, quo_q[DATA_W-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      quo_nx = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
      rem_nx = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
   end

   assign unused_bits = ^{prod[2*DATA_W-1:DATA_W],
                          sw_ext[IN_W+DATA_W-1:DATA_W]};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      regs_d  = regs_q;
      led_d   = led_q;
      flags_d = flags_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      drd_d   = drd_q;
      unique case (state_q)
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_q + PC_W'(1);
            if (op[5:4] == 2'b00) begin
               unique case (op[3:0])
                  4'd0: begin
                     regs_d[rd] = sum[DATA_W-1:0];
                     flags_d    = add_fl;
                  end
                  4'd1: begin
                     regs_d[rd] = dif[DATA_W-1:0];
                     flags_d    = sub_fl;
                  end
                  4'd2: regs_d[rd] = prod[DATA_W-1:0];
                  4'd3: begin
                     quo_d   = a;
                     rem_d   = '0;
                     dvs_d   = b;
                     cnt_d   = '0;
                     drd_d   = rd;
                     pc_d    = pc_q;
                     state_d = S_DIV;
                  end
                  4'd4: regs_d[rd] = imm;
                  4'd5: if (a != b) pc_d = imm[PC_W-1:0];
                  4'd6: if (a == b) pc_d = imm[PC_W-1:0];
                  4'd7: regs_d[rd] = b;
                  4'd8: begin
                     regs_d[rd] = sum[DATA_W-1:0];
                     flags_d    = add_fl;
                  end
                  4'd9:  regs_d[rd] = sw_ext[DATA_W-1:0];
                  4'd10: led_d = a;
                  4'd11: begin
                     pc_d    = pc_q;
                     state_d = S_HALT;
                  end
                  default: ;
               endcase
            end
         end
         S_DIV: begin
            quo_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W-1)) begin
               regs_d[drd_q] = quo_nx;
               pc_d          = pc_q + PC_W'(1);
               cnt_d         = '0;
               state_d       = S_FETCH;
            end
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         led_q   <= '0;
         flags_q <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         drd_q   <= '0;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else if (run_en) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         led_q   <= led_d;
         flags_q <= flags_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         drd_q   <= drd_d;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign imem_addr = pc_q;
   assign led       = led_q;
   assign flags     = flags_q;
   assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_pico_mips_mc.sv
// Testbench for pico_mips_mc: ROM-driven programs with a cycle-keyed
// scoreboard of expected led/flags/halted/pc values.
module tb_pico_mips_mc;

   localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, MUL = 6'd2, DIV = 6'd3;
   localparam logic [5:0] LDI = 6'd4, BNE = 6'd5, BEQ = 6'd6, MOV = 6'd7;
   localparam logic [5:0] ADDI = 6'd8, INP = 6'd9, OUT = 6'd10, HLT = 6'd11;
   localparam logic [23:0] NOP = 24'hC00000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run_en = 1'b1;
   logic [7:0]  imem_addr;
   logic [23:0] imem_rdata;
   logic [8:0]  sw = '0;
   logic [7:0]  led;
   logic [3:0]  flags;
   logic        halted;

   logic [23:0] rom [256];

   typedef struct {
      int         cyc;
      logic [7:0] led;
      logic [3:0] fl;
      logic       h;
      logic [7:0] pc;
   } ev_t;

   ev_t   sb[$];
   int    checks = 0;
   int    errors = 0;
   string tname = "";
   int    frz_lo = -1, frz_hi = -1, rst_a = -1, rst_b = -1;

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= rom[imem_addr];

   pico_mips_mc dut (
      .clk(clk),
      .rst(rst),
      .run_en(run_en),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .sw(sw),
      .led(led),
      .flags(flags),
      .halted(halted)
   );

   function automatic logic [23:0] ins(input logic [5:0] op, input int rd,
                                       input int rs, input logic [7:0] imm);
      logic [4:0] d, s;
      d = rd[4:0];
      s = rs[4:0];
      return {op, d, s, imm};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = NOP;
      frz_lo = -1; frz_hi = -1; rst_a = -1; rst_b = -1;
   endtask

   task automatic expect_ev(input int c, input logic [7:0] l,
                            input logic [3:0] f, input logic h,
                            input logic [7:0] p);
      ev_t e;
      e.cyc = c; e.led = l; e.fl = f; e.h = h; e.pc = p;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      run_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // cycle 0 is the first cycle after reset release; sampled at negedge
   task automatic run(input int ncyc);
      ev_t e;
      for (int c = 0; c < ncyc; c++) begin
         run_en = !(c >= frz_lo && c < frz_hi);
         rst = (c == rst_a) || (c == rst_b);
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks += 4;
            if (led !== e.led) begin
               errors++;
               $display("FAIL %s led cyc %0d got %h exp %h", tname, c, led, e.led);
            end
            if (flags !== e.fl) begin
               errors++;
               $display("FAIL %s flags cyc %0d got %b exp %b", tname, c, flags, e.fl);
            end
            if (halted !== e.h) begin
               errors++;
               $display("FAIL %s halted cyc %0d got %b exp %b", tname, c, halted, e.h);
            end
            if (imem_addr !== e.pc) begin
               errors++;
               $display("FAIL %s pc cyc %0d got %h exp %h", tname, c, imem_addr, e.pc);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b0;
      run_en = 1'b1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s unconsumed events got %0d exp 0", tname, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      tname = "reset";
      clear_rom();
      rom[0] = ins(LDI, 1, 0, 8'h5);
      rom[1] = ins(LDI, 2, 0, 8'h3);
      rom[2] = ins(ADD, 1, 2, 8'h0);
      rom[3] = ins(OUT, 1, 0, 8'h0);
      rom[4] = ins(HLT, 0, 0, 8'h0);
      do_reset();
      expect_ev(0, 8'h00, 4'h0, 1'b0, 8'h00);
      expect_ev(7, 8'h00, 4'h0, 1'b0, 8'h03);
      expect_ev(8, 8'h08, 4'h0, 1'b0, 8'h04);
      expect_ev(9, 8'h08, 4'h0, 1'b0, 8'h04);
      expect_ev(10, 8'h08, 4'h0, 1'b1, 8'h04);
      expect_ev(20, 8'h08, 4'h0, 1'b1, 8'h04);
      run(22);
   endtask

   task automatic test_sub_flags();
      tname = "sub_flags";
      clear_rom();
      rom[0] = ins(LDI, 1, 0, 8'h03);
      rom[1] = ins(LDI, 2, 0, 8'h05);
      rom[2] = ins(SUB, 1, 2, 8'h00);
      rom[3] = ins(OUT, 1, 0, 8'h00);
      rom[4] = ins(ADDI, 1, 0, 8'h02);
      rom[5] = ins(OUT, 1, 0, 8'h00);
      rom[6] = ins(LDI, 3, 0, 8'h7F);
      rom[7] = ins(ADDI, 3, 0, 8'h01);
      rom[8] = ins(HLT, 0, 0, 8'h00);
      do_reset();
      expect_ev(0, 8'h00, 4'h0, 1'b0, 8'h00);
      expect_ev(6, 8'h00, 4'b1010, 1'b0, 8'h03);
      expect_ev(8, 8'hFE, 4'b1010, 1'b0, 8'h04);
      expect_ev(10, 8'hFE, 4'b0011, 1'b0, 8'h05);
      expect_ev(12, 8'h00, 4'b0011, 1'b0, 8'h06);
      expect_ev(14, 8'h00, 4'b0011, 1'b0, 8'h07);
      expect_ev(16, 8'h00, 4'b1100, 1'b0, 8'h08);
      expect_ev(18, 8'h00, 4'b1100, 1'b1, 8'h08);
      run(20);
   endtask

   task automatic test_div(input logic [7:0] n, input logic [7:0] d,
                           input logic [7:0] q);
      tname = "div";
      clear_rom();
      rom[0] = ins(LDI, 1, 0, n);
      rom[1] = ins(LDI, 2, 0, d);
      rom[2] = ins(DIV, 1, 2, 8'h00);
      rom[3] = ins(OUT, 1, 0, 8'h00);
      rom[4] = ins(HLT, 0, 0, 8'h00);
      do_reset();
      expect_ev(0, 8'h00, 4'h0, 1'b0, 8'h00);
      expect_ev(13, 8'h00, 4'h0, 1'b0, 8'h02);
      expect_ev(14, 8'h00, 4'h0, 1'b0, 8'h03);
      expect_ev(16, q, 4'h0, 1'b0, 8'h04);
      expect_ev(17, q, 4'h0, 1'b0, 8'h04);
      expect_ev(18, q, 4'h0, 1'b1, 8'h04);
      run(20);
   endtask

   task automatic test_div_freeze();
      tname = "div_freeze";
      clear_rom();
      rom[0] = ins(LDI, 1, 0, 8'd200);
      rom[1] = ins(LDI, 2, 0, 8'd7);
      rom[2] = ins(DIV, 1, 2, 8'h00);
      rom[3] = ins(OUT, 1, 0, 8'h00);
      rom[4] = ins(HLT, 0, 0, 8'h00);
      do_reset();
      frz_lo = 8;
      frz_hi = 11;
      expect_ev(10, 8'h00, 4'h0, 1'b0, 8'h02);
      expect_ev(16, 8'h00, 4'h0, 1'b0, 8'h02);
      expect_ev(17, 8'h00, 4'h0, 1'b0, 8'h03);
      expect_ev(19, 8'd28, 4'h0, 1'b0, 8'h04);
      expect_ev(20, 8'd28, 4'h0, 1'b0, 8'h04);
      expect_ev(21, 8'd28, 4'h0, 1'b1, 8'h04);
      run(24);
   endtask

   task automatic test_loop();
      tname = "loop";
      clear_rom();
      rom[0] = ins(LDI, 1, 0, 8'h0);
      rom[1] = ins(LDI, 2, 0, 8'h4);
      rom[2] = ins(LDI, 3, 0, 8'h1);
      rom[3] = ins(ADD, 1, 3, 8'h0);
      rom[4] = ins(BNE, 1, 2, 8'h3);
      rom[5] = ins(OUT, 1, 0, 8'h0);
      rom[6] = ins(HLT, 0, 0, 8'h0);
      do_reset();
      expect_ev(0, 8'h00, 4'h0, 1'b0, 8'h00);
      expect_ev(10, 8'h00, 4'h0, 1'b0, 8'h03);
      expect_ev(23, 8'h00, 4'h0, 1'b0, 8'h05);
      expect_ev(24, 8'h04, 4'h0, 1'b0, 8'h06);
      expect_ev(25, 8'h04, 4'h0, 1'b0, 8'h06);
      expect_ev(26, 8'h04, 4'h0, 1'b1, 8'h06);
      expect_ev(30, 8'h04, 4'h0, 1'b1, 8'h06);
      run(32);
   endtask

   task automatic test_in_mul();
      tname = "in_mul";
      clear_rom();
      sw = 9'h1A5;
      rom[0]  = ins(INP, 4, 0, 8'h00);
      rom[1]  = ins(LDI, 5, 0, 8'h02);
      rom[2]  = ins(MUL, 4, 5, 8'h00);
      rom[3]  = ins(OUT, 4, 0, 8'h00);
      rom[4]  = ins(MOV, 6, 4, 8'h00);
      rom[5]  = ins(BEQ, 6, 4, 8'h08);
      rom[6]  = ins(OUT, 5, 0, 8'h00);
      rom[7]  = ins(HLT, 0, 0, 8'h00);
      rom[8]  = ins(LDI, 7, 0, 8'h55);
      rom[9]  = ins(BEQ, 7, 4, 8'h00);
      rom[10] = ins(OUT, 7, 0, 8'h00);
      rom[11] = ins(HLT, 0, 0, 8'h00);
      do_reset();
      expect_ev(8, 8'h4A, 4'h0, 1'b0, 8'h04);
      expect_ev(12, 8'h4A, 4'h0, 1'b0, 8'h08);
      expect_ev(16, 8'h4A, 4'h0, 1'b0, 8'h0A);
      expect_ev(18, 8'h55, 4'h0, 1'b0, 8'h0B);
      expect_ev(20, 8'h55, 4'h0, 1'b1, 8'h0B);
      run(22);
      sw = '0;
   endtask

   task automatic test_pc_wrap();
      tname = "pc_wrap";
      clear_rom();
      rom[0]   = ins(BEQ, 2, 0, 8'hFE);
      rom[1]   = ins(HLT, 0, 0, 8'h00);
      rom[254] = ins(LDI, 2, 0, 8'h3C);
      rom[255] = ins(OUT, 2, 0, 8'h00);
      do_reset();
      expect_ev(2, 8'h00, 4'h0, 1'b0, 8'hFE);
      expect_ev(4, 8'h00, 4'h0, 1'b0, 8'hFF);
      expect_ev(6, 8'h3C, 4'h0, 1'b0, 8'h00);
      expect_ev(8, 8'h3C, 4'h0, 1'b0, 8'h01);
      expect_ev(10, 8'h3C, 4'h0, 1'b1, 8'h01);
      run(12);
      checks++;
      if (imem_addr !== 8'h01) begin
         errors++;
         $display("FAIL pc_wrap final pc got %h exp 01", imem_addr);
      end
   endtask

   task automatic test_back_to_back_reset();
      tname = "reset_mid";
      clear_rom();
      rom[0] = ins(LDI, 1, 0, 8'hC8);
      rom[1] = ins(ADDI, 1, 0, 8'h80);
      rom[2] = ins(OUT, 1, 0, 8'h00);
      rom[3] = ins(LDI, 2, 0, 8'h07);
      rom[4] = ins(DIV, 1, 2, 8'h00);
      rom[5] = ins(OUT, 1, 0, 8'h00);
      rom[6] = ins(HLT, 0, 0, 8'h00);
      do_reset();
      rst_a = 12;
      rst_b = 38;
      frz_lo = 38;
      frz_hi = 39;
      expect_ev(0, 8'h00, 4'h0, 1'b0, 8'h00);
      expect_ev(4, 8'h00, 4'h6, 1'b0, 8'h02);
      expect_ev(6, 8'h48, 4'h6, 1'b0, 8'h03);
      expect_ev(12, 8'h48, 4'h6, 1'b0, 8'h04);
      expect_ev(13, 8'h00, 4'h0, 1'b0, 8'h00);
      expect_ev(17, 8'h00, 4'h6, 1'b0, 8'h02);
      expect_ev(19, 8'h48, 4'h6, 1'b0, 8'h03);
      expect_ev(31, 8'h48, 4'h6, 1'b0, 8'h05);
      expect_ev(33, 8'h0A, 4'h6, 1'b0, 8'h06);
      expect_ev(35, 8'h0A, 4'h6, 1'b1, 8'h06);
      expect_ev(38, 8'h0A, 4'h6, 1'b1, 8'h06);
      expect_ev(39, 8'h00, 4'h0, 1'b0, 8'h00);
      expect_ev(45, 8'h48, 4'h6, 1'b0, 8'h03);
      run(46);
   endtask

   initial begin
      test_reset();
      test_sub_flags();
      test_div(8'd200, 8'd7, 8'd28);
      test_div(8'd200, 8'd0, 8'hFF);
      test_div(8'd255, 8'd16, 8'd15);
      test_div(8'd7, 8'd200, 8'd0);
      test_div_freeze();
      test_loop();
      test_in_mul();
      test_pc_wrap();
      test_back_to_back_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
